// File: rtl/uart_hex_word_tx_pkg.sv
// Shared definitions for the UART hex word feeder: ASCII control bytes,
// FSM state encoding and the nibble-to-ASCII helper.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Uppercase hex: 0..9 -> '0'..'9', 10..15 -> 'A'..'F'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end else begin
      return 8'h37 + {4'h0, nibble};
    end
  endfunction

endpackage

// File: rtl/uart_hex_word_tx_if.sv
// Handshake bundle between the word source, the hex feeder and the byte transmitter.
interface uart_hex_word_tx_if;

  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  data_byte;
  logic        send_en;
  logic        tx_done;
  logic        frame_done;
  logic        busy;

  modport master (
    output word_in, word_valid, tx_done,
    input  word_ready, data_byte, send_en, frame_done, busy
  );

  modport slave (
    input  word_in, word_valid, tx_done,
    output word_ready, data_byte, send_en, frame_done, busy
  );

endinterface

// File: rtl/uart_hex_word_tx_hex_byte_sel.sv
// Combinational selector: picks the ASCII byte for a given frame index
// (eight hex digits MSB first, then optional CR LF).
module hex_byte_sel
  import uart_pkg::*;
#(
  parameter int ADD_CRLF = 1
) (
  input  logic [31:0] i_word,
  input  logic [3:0]  i_byte_idx,
  output logic [7:0]  o_byte
);

  logic [3:0] w_nibble;

  always_comb begin
    w_nibble = i_word[31:28];
    case (i_byte_idx[2:0])
      3'd0: w_nibble = i_word[31:28];
      3'd1: w_nibble = i_word[27:24];
      3'd2: w_nibble = i_word[23:20];
      3'd3: w_nibble = i_word[19:16];
      3'd4: w_nibble = i_word[15:12];
      3'd5: w_nibble = i_word[11:8];
      3'd6: w_nibble = i_word[7:4];
      3'd7: w_nibble = i_word[3:0];
      default: w_nibble = i_word[31:28];
    endcase
  end

  // Indices past the last valid one produce 0x00; the FSM never sends them
  always_comb begin
    o_byte = 8'h00;
    if (i_byte_idx < 4'd8) begin
      o_byte = nibble_to_ascii(w_nibble);
    end else if ((ADD_CRLF != 0) && (i_byte_idx == 4'd8)) begin
      o_byte = ASCII_CR;
    end else if ((ADD_CRLF != 0) && (i_byte_idx == 4'd9)) begin
      o_byte = ASCII_LF;
    end
  end

endmodule

// File: rtl/uart_hex_word_tx.sv
// Accepts a 32-bit word and feeds it, as ASCII hex (plus optional CR LF),
// one byte at a time into the UART byte transmitter.
module uart_hex_word_tx
  import uart_pkg::*;
#(
  parameter int ADD_CRLF = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_hex_word_tx_if.slave io_bus
);

  localparam logic [3:0] LAST_IDX = (ADD_CRLF != 0) ? 4'd9 : 4'd7;

  state_t      r_state;
  logic [31:0] r_word_reg;
  logic [3:0]  r_byte_idx;
  logic [7:0]  r_data_byte;
  logic        r_send_en;
  logic        r_frame_done;
  logic        r_word_ready;
  logic        r_busy;

  logic        w_accept;
  logic [31:0] w_sel_word;
  logic [3:0]  w_sel_idx;
  logic [7:0]  w_next_byte;

  assign w_accept = io_bus.word_valid && r_word_ready;

  // In IDLE the first byte comes straight from word_in so it is ready one cycle after accept
  assign w_sel_word = (r_state == IDLE) ? io_bus.word_in : r_word_reg;
  assign w_sel_idx  = (r_state == IDLE) ? 4'd0 : (r_byte_idx + 4'd1);

  hex_byte_sel #(
    .ADD_CRLF(ADD_CRLF)
  ) u_hex_byte_sel (
    .i_word     (w_sel_word),
    .i_byte_idx (w_sel_idx),
    .o_byte     (w_next_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_word_reg   <= '0;
      r_byte_idx   <= '0;
      r_data_byte  <= '0;
      r_send_en    <= 1'b0;
      r_frame_done <= 1'b0;
      r_word_ready <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_word_reg   <= io_bus.word_in;
            r_byte_idx   <= 4'd0;
            r_data_byte  <= w_next_byte;
            r_send_en    <= 1'b1;
            r_word_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= SEND;
          end else begin
            r_word_ready <= 1'b1;
          end
        end
        SEND: begin
          r_send_en <= 1'b0;
          r_state   <= WAIT;
        end
        WAIT: begin
          // tx_done only matters here; stray pulses in other states are dropped
          if (io_bus.tx_done) begin
            if (r_byte_idx != LAST_IDX) begin
              r_byte_idx  <= r_byte_idx + 4'd1;
              r_data_byte <= w_next_byte;
              r_send_en   <= 1'b1;
              r_state     <= SEND;
            end else begin
              r_frame_done <= 1'b1;
              r_state      <= DONE;
            end
          end
        end
        DONE: begin
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_word_ready <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.word_ready = r_word_ready;
  assign io_bus.data_byte  = r_data_byte;
  assign io_bus.send_en    = r_send_en;
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.busy       = r_busy;

endmodule
